// File: rtl/watchdog_ng_pkg.sv
// rtl/watchdog_ng_pkg.sv - shared constants and types for the watchdog_ng block
//
// Holds the CSR offsets (relative to BASE_ADDR), the CTRL/STAT bit positions
// and the watchdog FSM state encoding. Imported by watchdog_ng and
// watchdog_ng_regs.
package watchdog_ng_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'd0;
  localparam logic [4:0] OFF_TOUT_L = 5'd1;
  localparam logic [4:0] OFF_TOUT_H = 5'd2;
  localparam logic [4:0] OFF_KICK   = 5'd3;
  localparam logic [4:0] OFF_CNT_L  = 5'd4;
  localparam logic [4:0] OFF_CNT_H  = 5'd5;
  localparam logic [4:0] OFF_PRE    = 5'd6;
  localparam logic [4:0] OFF_STAT   = 5'd7;
  localparam logic [4:0] OFF_WIN    = 5'd8;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_FAILSAFE = 1;
  localparam int CTRL_LOCKED   = 2;
  localparam int CTRL_PRE_IE   = 3;
  localparam int CTRL_OE_LSB   = 4;

  localparam int STAT_PRE   = 0;
  localparam int STAT_BITE  = 1;
  localparam int STAT_EARLY = 2;

  typedef enum logic [1:0] {
    DISABLED   = 2'd0,
    RUNNING    = 2'd1,
    PRETIMEOUT = 2'd2,
    BITTEN     = 2'd3
  } wdt_state_e;

endpackage

// File: rtl/watchdog_ng_regs.sv
// rtl/watchdog_ng_regs.sv - CSR decode, lock, status flags and counter snapshot
//
// Optional feature macro: WATCHDOG_NG_WINDOW_EN (adds WIN register, early-kick
// detection and STAT[2] early_flag).
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   sys_rst_i            synchronous reset of config registers and flags
//   csr_a_i/di_i/we_i/re_i, csr_do_o   CSR bus (read data combinational)
//   wdt_en_default_i     {failsafe, en} loaded on either reset
//   cnt_i                live counter value (read and snapshot source)
//   set_pre_i/set_bite_i flag set pulses from the FSM
//   en_o .. pre_o        decoded configuration
//   kick_o               valid magic kick written this cycle
//   early_kick_o         valid kick outside the allowed window
module watchdog_ng_regs
  import watchdog_ng_pkg::*;
#(
  parameter logic [4:0]           BASE_ADDR       = 5'h0,
  parameter int                   CNT_WIDTH       = 16,
  parameter int                   NUM_OUT         = 2,
  parameter logic [NUM_OUT-1:0]   DEFAULT_OE      = '0,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_TIMEOUT = '1,
  parameter logic [7:0]           DEFAULT_PRETOUT = 8'h00,
  parameter logic [7:0]           KICK_VALUE      = 8'h6b
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sys_rst_i,
  input  logic [4:0]           csr_a_i,
  input  logic [7:0]           csr_di_i,
  input  logic                 csr_we_i,
  input  logic                 csr_re_i,
  output logic [7:0]           csr_do_o,
  input  logic [1:0]           wdt_en_default_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 set_pre_i,
  input  logic                 set_bite_i,
  output logic                 en_o,
  output logic                 failsafe_o,
  output logic                 pre_ie_o,
  output logic [NUM_OUT-1:0]   oe_o,
  output logic [CNT_WIDTH-1:0] tout_o,
  output logic [7:0]           pre_o,
  output logic                 kick_o,
  output logic                 early_kick_o
);

  localparam int HW = CNT_WIDTH - 8;

  logic               en_q, en_d, failsafe_q, failsafe_d, locked_q, locked_d;
  logic               pre_ie_q, pre_ie_d;
  logic [NUM_OUT-1:0] oe_q, oe_d;
  logic [7:0]         tout_l_q, tout_l_d, pre_q, pre_d;
  logic [HW-1:0]      tout_h_q, tout_h_d, shadow_q, shadow_d;
  logic               pre_flag_q, pre_flag_d, bite_flag_q, bite_flag_d;
  logic [4:0]         off;
  logic               cfg_wr, stat_wr;
  logic [7:0]         ctrl_rd, tout_h_rd, stat_rd, cnt_h_rd;
`ifdef WATCHDOG_NG_WINDOW_EN
  logic [7:0]         win_q, win_d;
  logic               early_flag_q, early_flag_d;
`endif

  assign off     = csr_a_i - BASE_ADDR;
  assign cfg_wr  = csr_we_i && !locked_q;
  assign stat_wr = csr_we_i && (off == OFF_STAT);
  assign kick_o  = csr_we_i && (off == OFF_KICK) && (csr_di_i == KICK_VALUE);

`ifdef WATCHDOG_NG_WINDOW_EN
  // Upper counter byte above WIN means the kick came too soon after the reload.
  assign early_kick_o = kick_o && en_q && (win_q != 8'hff) &&
                        (cnt_i[CNT_WIDTH-1 -: 8] > win_q);
`else
  assign early_kick_o = 1'b0;
`endif

  always_comb begin
    en_d        = en_q;
    failsafe_d  = failsafe_q;
    locked_d    = locked_q;
    pre_ie_d    = pre_ie_q;
    oe_d        = oe_q;
    tout_l_d    = tout_l_q;
    tout_h_d    = tout_h_q;
    pre_d       = pre_q;
    shadow_d    = shadow_q;
    if (cfg_wr && off == OFF_CTRL) begin
      // Failsafe is sticky and, once set, en can no longer be cleared.
      en_d       = csr_di_i[CTRL_EN] | (failsafe_q & en_q);
      failsafe_d = csr_di_i[CTRL_FAILSAFE] | failsafe_q;
      locked_d   = csr_di_i[CTRL_LOCKED];
      pre_ie_d   = csr_di_i[CTRL_PRE_IE];
      oe_d       = csr_di_i[CTRL_OE_LSB +: NUM_OUT];
    end
    if (cfg_wr && off == OFF_TOUT_L) tout_l_d = csr_di_i;
    if (cfg_wr && off == OFF_TOUT_H) tout_h_d = csr_di_i[HW-1:0];
    if (cfg_wr && off == OFF_PRE)    pre_d    = csr_di_i;
    // A set in the same cycle as a write-1-to-clear wins.
    pre_flag_d  = (pre_flag_q  & ~(stat_wr & csr_di_i[STAT_PRE]))  | set_pre_i;
    bite_flag_d = (bite_flag_q & ~(stat_wr & csr_di_i[STAT_BITE])) | set_bite_i;
    if (csr_re_i && off == OFF_CNT_L) shadow_d = cnt_i[CNT_WIDTH-1:8];
`ifdef WATCHDOG_NG_WINDOW_EN
    win_d        = win_q;
    if (cfg_wr && off == OFF_WIN) win_d = csr_di_i;
    early_flag_d = (early_flag_q & ~(stat_wr & csr_di_i[STAT_EARLY])) | early_kick_o;
`endif
    if (sys_rst_i) begin
      en_d        = wdt_en_default_i[0];
      failsafe_d  = wdt_en_default_i[1];
      locked_d    = 1'b0;
      pre_ie_d    = 1'b0;
      oe_d        = DEFAULT_OE;
      tout_l_d    = DEFAULT_TIMEOUT[7:0];
      tout_h_d    = DEFAULT_TIMEOUT[CNT_WIDTH-1:8];
      pre_d       = DEFAULT_PRETOUT;
      pre_flag_d  = 1'b0;
      bite_flag_d = 1'b0;
      shadow_d    = '0;
`ifdef WATCHDOG_NG_WINDOW_EN
      win_d        = 8'hff;
      early_flag_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q        <= wdt_en_default_i[0];
      failsafe_q  <= wdt_en_default_i[1];
      locked_q    <= 1'b0;
      pre_ie_q    <= 1'b0;
      oe_q        <= DEFAULT_OE;
      tout_l_q    <= DEFAULT_TIMEOUT[7:0];
      tout_h_q    <= DEFAULT_TIMEOUT[CNT_WIDTH-1:8];
      pre_q       <= DEFAULT_PRETOUT;
      pre_flag_q  <= 1'b0;
      bite_flag_q <= 1'b0;
      shadow_q    <= '0;
`ifdef WATCHDOG_NG_WINDOW_EN
      win_q        <= 8'hff;
      early_flag_q <= 1'b0;
`endif
    end else begin
      en_q        <= en_d;
      failsafe_q  <= failsafe_d;
      locked_q    <= locked_d;
      pre_ie_q    <= pre_ie_d;
      oe_q        <= oe_d;
      tout_l_q    <= tout_l_d;
      tout_h_q    <= tout_h_d;
      pre_q       <= pre_d;
      pre_flag_q  <= pre_flag_d;
      bite_flag_q <= bite_flag_d;
      shadow_q    <= shadow_d;
`ifdef WATCHDOG_NG_WINDOW_EN
      win_q        <= win_d;
      early_flag_q <= early_flag_d;
`endif
    end
  end

  always_comb begin
    ctrl_rd                           = '0;
    ctrl_rd[CTRL_EN]                  = en_q;
    ctrl_rd[CTRL_FAILSAFE]            = failsafe_q;
    ctrl_rd[CTRL_LOCKED]              = locked_q;
    ctrl_rd[CTRL_PRE_IE]              = pre_ie_q;
    ctrl_rd[CTRL_OE_LSB +: NUM_OUT]   = oe_q;
    tout_h_rd                         = '0;
    tout_h_rd[HW-1:0]                 = tout_h_q;
    cnt_h_rd                          = '0;
    cnt_h_rd[HW-1:0]                  = shadow_q;
    stat_rd                           = '0;
    stat_rd[STAT_PRE]                 = pre_flag_q;
    stat_rd[STAT_BITE]                = bite_flag_q;
`ifdef WATCHDOG_NG_WINDOW_EN
    stat_rd[STAT_EARLY]               = early_flag_q;
`endif
    csr_do_o = 8'h00;
    case (off)
      OFF_CTRL:   csr_do_o = ctrl_rd;
      OFF_TOUT_L: csr_do_o = tout_l_q;
      OFF_TOUT_H: csr_do_o = tout_h_rd;
      OFF_CNT_L:  csr_do_o = cnt_i[7:0];
      OFF_CNT_H:  csr_do_o = cnt_h_rd;
      OFF_PRE:    csr_do_o = pre_q;
      OFF_STAT:   csr_do_o = stat_rd;
`ifdef WATCHDOG_NG_WINDOW_EN
      OFF_WIN:    csr_do_o = win_q;
`endif
      default:    csr_do_o = 8'h00;
    endcase
  end

  assign en_o       = en_q;
  assign failsafe_o = failsafe_q;
  assign pre_ie_o   = pre_ie_q;
  assign oe_o       = oe_q;
  assign tout_o     = {tout_h_q, tout_l_q};
  assign pre_o      = pre_q;

endmodule

// File: rtl/watchdog_ng.sv
// rtl/watchdog_ng.sv - watchdog with pretimeout irq, gated bite outputs and failsafe
//
// Optional feature macro: WATCHDOG_NG_WINDOW_EN (windowed kick, see watchdog_ng_regs).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low power-on reset
//   sys_rst               synchronous system reset (counter kept in failsafe)
//   ce                    count tick enable
//   pwr_is_off            reload counter from timeout and hold DISABLED
//   csr_a/di/we/re/do     CSR bus, 8-register window at BASE_ADDR
//   wdt_en_default        {failsafe, en} loaded on reset
//   wdt_out               level bite per enabled output
//   wdt_out_strobe        one-cycle bite pulse per enabled output
//   force_recovery_mode   bitten while failsafe
//   irq                   pulse on pretimeout entry (if pre_ie) or bite entry
module watchdog_ng
  import watchdog_ng_pkg::*;
#(
  parameter logic [4:0]           BASE_ADDR       = 5'h0,
  parameter int                   CNT_WIDTH       = 16,
  parameter int                   NUM_OUT         = 2,
  parameter logic [NUM_OUT-1:0]   DEFAULT_OE      = '0,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_TIMEOUT = '1,
  parameter logic [7:0]           DEFAULT_PRETOUT = 8'h00,
  parameter logic [7:0]           KICK_VALUE      = 8'h6b
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sys_rst,
  input  logic               ce,
  input  logic               pwr_is_off,
  input  logic [4:0]         csr_a,
  input  logic [7:0]         csr_di,
  input  logic               csr_we,
  input  logic               csr_re,
  output logic [7:0]         csr_do,
  input  logic [1:0]         wdt_en_default,
  output logic [NUM_OUT-1:0] wdt_out,
  output logic [NUM_OUT-1:0] wdt_out_strobe,
  output logic               force_recovery_mode,
  output logic               irq
);

  logic                 en, failsafe, pre_ie, kick, early_kick;
  logic [NUM_OUT-1:0]   oe;
  logic [CNT_WIDTH-1:0] tout, pre_ext, cnt_q, cnt_d, cnt_dec;
  logic [7:0]           pre;
  wdt_state_e           state_q, state_d;
  logic                 enter_pre, enter_bite;
  logic [NUM_OUT-1:0]   wdt_out_q, strobe_q;
  logic                 irq_q, frm_q;

  watchdog_ng_regs #(
    .BASE_ADDR       (BASE_ADDR),
    .CNT_WIDTH       (CNT_WIDTH),
    .NUM_OUT         (NUM_OUT),
    .DEFAULT_OE      (DEFAULT_OE),
    .DEFAULT_TIMEOUT (DEFAULT_TIMEOUT),
    .DEFAULT_PRETOUT (DEFAULT_PRETOUT),
    .KICK_VALUE      (KICK_VALUE)
  ) u_regs (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .sys_rst_i        (sys_rst),
    .csr_a_i          (csr_a),
    .csr_di_i         (csr_di),
    .csr_we_i         (csr_we),
    .csr_re_i         (csr_re),
    .csr_do_o         (csr_do),
    .wdt_en_default_i (wdt_en_default),
    .cnt_i            (cnt_q),
    .set_pre_i        (enter_pre),
    .set_bite_i       (enter_bite),
    .en_o             (en),
    .failsafe_o       (failsafe),
    .pre_ie_o         (pre_ie),
    .oe_o             (oe),
    .tout_o           (tout),
    .pre_o            (pre),
    .kick_o           (kick),
    .early_kick_o     (early_kick)
  );

  assign pre_ext = CNT_WIDTH'(pre);
  // Saturating decrement: the counter never wraps past zero.
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_WIDTH'(1);

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (pwr_is_off) begin
      cnt_d   = tout;
      state_d = DISABLED;
    end else if (sys_rst) begin
      // In failsafe a system reset must not rescue a stuck system.
      if (!failsafe) begin
        cnt_d   = DEFAULT_TIMEOUT;
        state_d = wdt_en_default[0] ? RUNNING : DISABLED;
      end
    end else if (early_kick) begin
      cnt_d   = '0;
      state_d = BITTEN;
    end else if (kick) begin
      cnt_d = tout;
      if (en) state_d = RUNNING;
    end else if (!en) begin
      state_d = DISABLED;
    end else if (ce && (state_q == RUNNING || state_q == PRETIMEOUT)) begin
      cnt_d = cnt_dec;
      if (cnt_dec == '0)
        state_d = BITTEN;
      else if (state_q == RUNNING && pre != 8'h00 && cnt_dec <= pre_ext)
        state_d = PRETIMEOUT;
    end
  end

  assign enter_pre  = (state_d == PRETIMEOUT) && (state_q != PRETIMEOUT);
  assign enter_bite = (state_d == BITTEN) && (state_q != BITTEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= DEFAULT_TIMEOUT;
      state_q   <= wdt_en_default[0] ? RUNNING : DISABLED;
      wdt_out_q <= '0;
      strobe_q  <= '0;
      irq_q     <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      wdt_out_q <= (state_d == BITTEN) ? oe : '0;
      strobe_q  <= enter_bite ? oe : '0;
      irq_q     <= (enter_pre && pre_ie) || enter_bite;
      frm_q     <= (state_d == BITTEN) && failsafe;
    end
  end

  assign wdt_out             = wdt_out_q;
  assign wdt_out_strobe      = strobe_q;
  assign irq                 = irq_q;
  assign force_recovery_mode = frm_q;

endmodule

// File: tb/tb_watchdog_ng.sv
// tb/tb_watchdog_ng.sv - directed self-checking bench for watchdog_ng
module tb_watchdog_ng;

  localparam logic [4:0] A_CTRL = 5'd0, A_TOUT_L = 5'd1, A_TOUT_H = 5'd2, A_KICK = 5'd3;
  localparam logic [4:0] A_CNT_L = 5'd4, A_CNT_H = 5'd5, A_PRE = 5'd6, A_STAT = 5'd7, A_WIN = 5'd8;

  logic       clk = 1'b0, rst_n = 1'b0, sys_rst = 1'b0, ce = 1'b0, pwr_is_off = 1'b0;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'h00, csr_do;
  logic       csr_we = 1'b0, csr_re = 1'b0;
  logic [1:0] wdt_en_default = 2'b01;
  logic [1:0] wdt_out, wdt_out_strobe;
  logic       force_recovery_mode, irq;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  watchdog_ng dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sys_rst             (sys_rst),
    .ce                  (ce),
    .pwr_is_off          (pwr_is_off),
    .csr_a               (csr_a),
    .csr_di              (csr_di),
    .csr_we              (csr_we),
    .csr_re              (csr_re),
    .csr_do              (csr_do),
    .wdt_en_default      (wdt_en_default),
    .wdt_out             (wdt_out),
    .wdt_out_strobe      (wdt_out_strobe),
    .force_recovery_mode (force_recovery_mode),
    .irq                 (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    csr_a = a;
    #1;
    d = csr_do;
  endtask

  task automatic pulse_sys_rst();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [7:0] exp_win;
`ifdef WATCHDOG_NG_WINDOW_EN
    exp_win = 8'hff;
`else
    exp_win = 8'h00;
`endif
    #12;
    checks++; if ({wdt_out, wdt_out_strobe, irq, force_recovery_mode} !== 6'b0) begin failures++; $display("FAIL reset_outs got=%b exp=0", {wdt_out, wdt_out_strobe, irq, force_recovery_mode}); end
    rd(A_CTRL, d);   checks++; if (d !== 8'h01) begin failures++; $display("FAIL reset_ctrl got=%h exp=01", d); end
    rd(A_TOUT_L, d); checks++; if (d !== 8'hff) begin failures++; $display("FAIL reset_tout_l got=%h exp=ff", d); end
    rd(A_TOUT_H, d); checks++; if (d !== 8'hff) begin failures++; $display("FAIL reset_tout_h got=%h exp=ff", d); end
    rd(A_CNT_L, d);  checks++; if (d !== 8'hff) begin failures++; $display("FAIL reset_cnt_l got=%h exp=ff", d); end
    rd(A_PRE, d);    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_pre got=%h exp=00", d); end
    rd(A_STAT, d);   checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_stat got=%h exp=00", d); end
    rd(A_WIN, d);    checks++; if (d !== exp_win) begin failures++; $display("FAIL reset_off8 got=%h exp=%h", d, exp_win); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_bite();
    logic [7:0] d;
    int irqs = 0, strobes = 0, exp;
    wr(A_CTRL, 8'h11); wr(A_TOUT_L, 8'h05); wr(A_TOUT_H, 8'h00);
    csr_a = A_KICK; csr_di = 8'h6b; csr_we = 1'b1; ce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      csr_we = 1'b0;
      rd(A_CNT_L, d);
      exp = (i < 5) ? 5 - i : 0;
      checks++; if (d !== 8'(exp)) begin failures++; $display("FAIL bite_cnt[%0d] got=%h exp=%h", i, d, 8'(exp)); end
      checks++; if (wdt_out !== ((exp == 0) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL bite_out[%0d] got=%b", i, wdt_out); end
      irqs += int'(irq);
      strobes += int'(wdt_out_strobe == 2'b01);
    end
    ce = 1'b0;
    checks++; if (irqs != 1) begin failures++; $display("FAIL bite_irq_count got=%0d exp=1", irqs); end
    checks++; if (strobes != 1) begin failures++; $display("FAIL bite_strobe_count got=%0d exp=1", strobes); end
    rd(A_STAT, d); checks++; if (d !== 8'h02) begin failures++; $display("FAIL bite_stat got=%h exp=02", d); end
  endtask

  task automatic test_pretimeout();
    logic [7:0] d;
    int exp;
    wr(A_STAT, 8'h03);
    rd(A_STAT, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL pre_stat_clr0 got=%h exp=00", d); end
    wr(A_CTRL, 8'h19); wr(A_PRE, 8'h03); wr(A_TOUT_L, 8'h0a); wr(A_TOUT_H, 8'h00);
    csr_a = A_KICK; csr_di = 8'h6b; csr_we = 1'b1; ce = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      csr_we = 1'b0;
      rd(A_CNT_L, d);
      exp = (i < 10) ? 10 - i : 0;
      checks++; if (d !== 8'(exp)) begin failures++; $display("FAIL pre_cnt[%0d] got=%h exp=%h", i, d, 8'(exp)); end
      checks++; if (irq !== (i == 7 || i == 10)) begin failures++; $display("FAIL pre_irq[%0d] got=%b", i, irq); end
    end
    ce = 1'b0;
    rd(A_STAT, d); checks++; if (d !== 8'h03) begin failures++; $display("FAIL pre_stat got=%h exp=03", d); end
    wr(A_STAT, 8'h03);
    rd(A_STAT, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL pre_stat_w1c got=%h exp=00", d); end
  endtask

  task automatic test_lock();
    logic [7:0] d;
    wr(A_TOUT_L, 8'h05); wr(A_CTRL, 8'h15);
    wr(A_TOUT_L, 8'hff); wr(A_TOUT_H, 8'h00);
    rd(A_TOUT_L, d); checks++; if (d !== 8'h05) begin failures++; $display("FAIL lock_tout_l got=%h exp=05", d); end
    wr(A_CTRL, 8'h00);
    rd(A_CTRL, d); checks++; if (d !== 8'h15) begin failures++; $display("FAIL lock_ctrl got=%h exp=15", d); end
    wr(A_KICK, 8'h6b);
    rd(A_CNT_L, d); checks++; if (d !== 8'h05) begin failures++; $display("FAIL lock_kick got=%h exp=05", d); end
    csr_a = A_KICK; csr_di = 8'h6a; csr_we = 1'b1; ce = 1'b1;
    tick();
    csr_we = 1'b0;
    rd(A_CNT_L, d); checks++; if (d !== 8'h04) begin failures++; $display("FAIL badkick_cnt0 got=%h exp=04", d); end
    tick();
    rd(A_CNT_L, d); checks++; if (d !== 8'h03) begin failures++; $display("FAIL badkick_cnt1 got=%h exp=03", d); end
    ce = 1'b0;
  endtask

  task automatic test_failsafe();
    logic [7:0] d;
    wdt_en_default = 2'b11;
    pulse_sys_rst();
    rd(A_CTRL, d);  checks++; if (d !== 8'h03) begin failures++; $display("FAIL fs_ctrl_rst got=%h exp=03", d); end
    rd(A_CNT_L, d); checks++; if (d !== 8'hff) begin failures++; $display("FAIL fs_cnt_rst got=%h exp=ff", d); end
    wr(A_TOUT_L, 8'h07); wr(A_TOUT_H, 8'h00); wr(A_KICK, 8'h6b);
    wr(A_CTRL, 8'h00);
    rd(A_CTRL, d); checks++; if (d !== 8'h03) begin failures++; $display("FAIL fs_en_clear got=%h exp=03", d); end
    pulse_sys_rst();
    rd(A_CNT_L, d); checks++; if (d !== 8'h07) begin failures++; $display("FAIL fs_cnt_hold got=%h exp=07", d); end
    checks++; if (force_recovery_mode !== 1'b0) begin failures++; $display("FAIL fs_frm_pre got=%b exp=0", force_recovery_mode); end
    ce = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    ce = 1'b0;
    rd(A_CNT_L, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL fs_cnt_zero got=%h exp=00", d); end
    checks++; if (force_recovery_mode !== 1'b1) begin failures++; $display("FAIL fs_frm got=%b exp=1", force_recovery_mode); end
    wdt_en_default = 2'b01;
    pulse_sys_rst();
    tick();
    rd(A_CTRL, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL nofs_ctrl got=%h exp=01", d); end
    checks++; if (force_recovery_mode !== 1'b0) begin failures++; $display("FAIL nofs_frm got=%b exp=0", force_recovery_mode); end
    wr(A_TOUT_L, 8'h07); wr(A_TOUT_H, 8'h00); wr(A_KICK, 8'h6b);
    pulse_sys_rst();
    rd(A_CNT_L, d); checks++; if (d !== 8'hff) begin failures++; $display("FAIL nofs_reload_l got=%h exp=ff", d); end
    csr_re = 1'b1;
    tick();
    csr_re = 1'b0;
    rd(A_CNT_H, d); checks++; if (d !== 8'hff) begin failures++; $display("FAIL nofs_reload_h got=%h exp=ff", d); end
  endtask

  task automatic test_snapshot();
    logic [7:0] d;
    wr(A_TOUT_L, 8'h00); wr(A_TOUT_H, 8'h01); wr(A_KICK, 8'h6b);
    csr_a = A_CNT_L; csr_re = 1'b1; ce = 1'b1;
    #1;
    checks++; if (csr_do !== 8'h00) begin failures++; $display("FAIL snap_cnt_l got=%h exp=00", csr_do); end
    tick();
    csr_re = 1'b0; ce = 1'b0;
    rd(A_CNT_H, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL snap_cnt_h got=%h exp=01", d); end
    rd(A_CNT_L, d); checks++; if (d !== 8'hff) begin failures++; $display("FAIL snap_cnt_l_after got=%h exp=ff", d); end
    pwr_is_off = 1'b1;
    tick();
    pwr_is_off = 1'b0; ce = 1'b1;
    tick(); tick();
    ce = 1'b0;
    rd(A_CNT_L, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL pwroff_hold got=%h exp=00", d); end
  endtask

`ifdef WATCHDOG_NG_WINDOW_EN
  task automatic test_window();
    logic [7:0] d;
    wr(A_WIN, 8'hff); wr(A_TOUT_L, 8'h80); wr(A_TOUT_H, 8'h01); wr(A_KICK, 8'h6b);
    wr(A_WIN, 8'h02); wr(A_TOUT_L, 8'h00); wr(A_TOUT_H, 8'h04);
    wr(A_KICK, 8'h6b);
    csr_re = 1'b1;
    rd(A_CNT_L, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL win_ok_l got=%h exp=00", d); end
    tick();
    csr_re = 1'b0;
    rd(A_CNT_H, d); checks++; if (d !== 8'h04) begin failures++; $display("FAIL win_ok_h got=%h exp=04", d); end
    rd(A_STAT, d);  checks++; if (d !== 8'h00) begin failures++; $display("FAIL win_ok_stat got=%h exp=00", d); end
    wr(A_KICK, 8'h6b);
    rd(A_STAT, d);  checks++; if (d !== 8'h06) begin failures++; $display("FAIL win_early_stat got=%h exp=06", d); end
    rd(A_CNT_L, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL win_early_cnt got=%h exp=00", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_bite();
    test_pretimeout();
    test_lock();
    test_failsafe();
    test_snapshot();
`ifdef WATCHDOG_NG_WINDOW_EN
    test_window();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
